// File: rtl/vjtag_cmd_ctrl.sv
// Command controller behind the 4-bit-IR virtual JTAG node. Decodes the IR, owns the DR
// shift register, turns completed DR scans into bus writes and prefetched reads.
// Runs entirely in the tck domain.
module vjtag_cmd_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              tck,
    input  logic              rst,
    input  logic              tdi,
    output logic              tdo,
    input  logic [3:0]        ir_in,
    output logic [3:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_cir,
    input  logic              virtual_state_uir,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StReady} rd_state_e;

    localparam int unsigned CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    localparam logic [3:0] IR_WR_ADDR = 4'd1;
    localparam logic [3:0] IR_WR_DATA = 4'd2;
    localparam logic [3:0] IR_RD_DATA = 4'd3;
    localparam logic [3:0] IR_CLR_ERR = 4'd4;

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q;
    logic              wr_seen_q;
    logic [2:0]        lat_q;
    rd_state_e         state_q, state_d;

    logic is_wr_addr, is_wr_data, is_rd_data, is_clr_err, is_byp, is_dr_cmd;
    logic cnt_ok, upd_wr_addr, upd_wr_data, upd_rd_data, upd_bad;
    logic rd_busy, rd_ready, lat_done;
    logic unused_strobes;

    // Pause/exit strobes carry no meaning for this node.
    assign unused_strobes = ^{virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr};

    assign is_wr_addr = (ir_in == IR_WR_ADDR);
    assign is_wr_data = (ir_in == IR_WR_DATA);
    assign is_rd_data = (ir_in == IR_RD_DATA);
    assign is_clr_err = (ir_in == IR_CLR_ERR);
    assign is_dr_cmd  = is_wr_addr | is_wr_data | is_rd_data;
    assign is_byp     = ~(is_dr_cmd | is_clr_err);

    // A DR update only takes effect after exactly one full word was shifted.
    assign cnt_ok      = (cnt_q == CNT_FULL);
    assign upd_wr_addr = virtual_state_udr & is_wr_addr & cnt_ok;
    assign upd_wr_data = virtual_state_udr & is_wr_data & cnt_ok;
    assign upd_rd_data = virtual_state_udr & is_rd_data & cnt_ok;
    assign upd_bad     = virtual_state_udr & is_dr_cmd & ~cnt_ok;

    assign rd_busy  = (state_q == StReq) || (state_q == StWait);
    assign rd_ready = (state_q == StReady);
    assign lat_done = (lat_q == 3'(RD_LAT));
    assign rd_en    = (state_q == StReq);

    // Next bus address: loaded on WR_ADDR, post-incremented (wrapping) on data accesses.
    always_comb begin
        addr_d = addr_q;
        if (upd_wr_addr) begin
            addr_d = sr_q[ADDR_W-1:0];
        end else if (upd_wr_data || upd_rd_data) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Read prefetch FSM next state; later assignments take precedence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReq:   state_d = StWait;
            StWait:  if (lat_done) state_d = StReady;
            default: ;
        endcase
        if (upd_rd_data || (upd_wr_addr && rd_busy)) begin
            state_d = StReq;
        end
        if (virtual_state_uir) begin
            if (!is_rd_data) begin
                state_d = StIdle;
            end else if (state_q == StIdle) begin
                state_d = StReq;
            end
        end
    end

    // Read FSM state, latency counter, request address and prefetched data.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            lat_q     <= 3'd0;
            rd_addr   <= '0;
            rd_hold_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == StReq) begin
                rd_addr <= addr_d;
            end
            if (state_q == StReq) begin
                lat_q <= 3'd1;
            end else if ((state_q == StWait) && !lat_done) begin
                lat_q <= lat_q + 3'd1;
            end
            if ((state_q == StWait) && lat_done) begin
                rd_hold_q <= rd_data;
            end
        end
    end

    // DR shift/capture/update datapath, status flags and write strobe; udr > cdr > sdr.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            tdo       <= 1'b0;
            ir_out    <= 4'b0001;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            addr_q    <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_seen_q <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            addr_q <= addr_d;
            if (virtual_state_udr) begin
                if (upd_wr_data) begin
                    wr_en     <= 1'b1;
                    wr_addr   <= addr_q;
                    wr_data   <= sr_q;
                    wr_seen_q <= 1'b1;
                end
                if (upd_bad) begin
                    err_q <= 1'b1;
                end
                if (is_clr_err) begin
                    err_q     <= 1'b0;
                    wr_seen_q <= 1'b0;
                end
            end else if (virtual_state_cdr) begin
                cnt_q <= '0;
                if (is_rd_data) begin
                    // Reading before the prefetch landed returns stale data and flags it.
                    sr_q <= rd_hold_q;
                    if (!rd_ready) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    sr_q <= '0;
                end
            end else if (virtual_state_sdr) begin
                if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (is_byp) begin
                    // The tdo flop doubles as the 1-bit bypass register.
                    tdo <= tdi;
                end else begin
                    tdo  <= sr_q[0];
                    sr_q <= {tdi, sr_q[DATA_W-1:1]};
                end
            end
            if (virtual_state_cir) begin
                ir_out <= {err_q, rd_ready, wr_seen_q, 1'b1};
            end
        end
    end

endmodule
